wallace_final_cpa: RTL and testbench

//  Final carry-propagate stage of the 32x32 Wallace multiplier in the Tomasulo multiply unit.
//  - Consumes the redundant sum/carry vector pair from the last CSA layer.
//  - Adds the pair in a 2-stage pipeline, split into a low half and a high half.
//  - Returns the 64-bit product with its reservation-station tag over a valid/ready handshake toward the CDB arbiter.

---
 rtl/mul_pkg.sv | 13 +
 rtl/cpa_checker.sv | 15 +
 rtl/half_cpa.sv | 16 +
 rtl/wallace_final_cpa.sv | 112 +++++++++++
 tb/tb_wallace_final_cpa.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_pkg.sv
// Shared constants and types for the Wallace multiplier datapath.
package mul_pkg;
  localparam int VEC_W  = 64;
  localparam int TAG_W  = 4;
  localparam int HALF_W = VEC_W / 2;

  typedef struct packed {
    logic [HALF_W-1:0] sum;
    logic [HALF_W-1:0] carry;
  } cpa_half_t;

  typedef logic [TAG_W-1:0] rs_tag_t;
endpackage

// File: rtl/cpa_checker.sv
// Flags a valid product whose final carry-out is set; no legal product overflows.
module cpa_checker (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic out_valid,
  input  logic out_cout,
  output logic violation
);

  assign violation = out_valid && out_cout;

  a_no_cout: assert property (@(posedge clk) disable iff (!rst_n || !en) out_valid |-> !out_cout);

endmodule

// File: rtl/half_cpa.sv
// Combinational W-bit carry-propagate adder with carry in and carry out.
module half_cpa
  import mul_pkg::*;
#(
  parameter int W = HALF_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/wallace_final_cpa.sv
// Two-stage final adder of the Wallace tree: low half in S1, high half plus
// the mid carry in S2, with a valid/ready handshake and a flush for mispredicts.
module wallace_final_cpa #(
  parameter int VEC_W = mul_pkg::VEC_W,
  parameter int TAG_W = mul_pkg::TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] in_sum,
  input  logic [VEC_W-1:0] in_carry,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VEC_W-1:0] out_product,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_cout
);

  localparam int H = VEC_W / 2;

  logic             s1_v_r;
  logic [H-1:0]     s1_lo_r;
  logic             s1_cmid_r;
  logic [H-1:0]     s1_sum_hi_r;
  logic [H-1:0]     s1_carry_hi_r;
  logic [TAG_W-1:0] s1_tag_r;

  logic [H-1:0] lo_s;
  logic [H-1:0] hi_s;
  logic         lo_cout_s;
  logic         hi_cout_s;
  logic         s2_free_s;
  logic         s1_adv_s;
  logic         accept_s;

  assign s2_free_s = !out_valid || out_ready;
  assign s1_adv_s  = s1_v_r && s2_free_s;
  assign in_ready  = !flush && (!s1_v_r || s2_free_s);
  assign accept_s  = in_valid && in_ready;

  half_cpa #(.W(H)) u_lo (
    .a    (in_sum[H-1:0]),
    .b    (in_carry[H-1:0]),
    .cin  (1'b0),
    .sum  (lo_s),
    .cout (lo_cout_s)
  );

  half_cpa #(.W(H)) u_hi (
    .a    (s1_sum_hi_r),
    .b    (s1_carry_hi_r),
    .cin  (s1_cmid_r),
    .sum  (hi_s),
    .cout (hi_cout_s)
  );

  // Valid bits: flush kills both stages and wins over any handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_r    <= 1'b0;
      out_valid <= 1'b0;
    end else if (flush) begin
      s1_v_r    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept_s) begin
        s1_v_r <= 1'b1;
      end else if (s1_adv_s) begin
        s1_v_r <= 1'b0;
      end
      if (s1_adv_s) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Stage 1 data: low-half sum, its carry, and the untouched upper halves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_lo_r       <= {H{1'b0}};
      s1_cmid_r     <= 1'b0;
      s1_sum_hi_r   <= {H{1'b0}};
      s1_carry_hi_r <= {H{1'b0}};
      s1_tag_r      <= {TAG_W{1'b0}};
    end else if (accept_s) begin
      s1_lo_r       <= lo_s;
      s1_cmid_r     <= lo_cout_s;
      s1_sum_hi_r   <= in_sum[VEC_W-1:H];
      s1_carry_hi_r <= in_carry[VEC_W-1:H];
      s1_tag_r      <= in_tag;
    end
  end

  // Stage 2 data doubles as the output registers; it only loads when S2 is free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_product <= {VEC_W{1'b0}};
      out_tag     <= {TAG_W{1'b0}};
      out_cout    <= 1'b0;
    end else if (s1_adv_s) begin
      out_product <= {hi_s, s1_lo_r};
      out_tag     <= s1_tag_r;
      out_cout    <= hi_cout_s;
    end
  end

endmodule

// File: tb/tb_wallace_final_cpa.sv
// Scoreboard bench for wallace_final_cpa: directed latency, streaming,
// backpressure, flush, wrap and async-reset cases followed by a random soak.
module tb_wallace_final_cpa;
  import mul_pkg::*;

  typedef struct packed {
    rs_tag_t          tag;
    logic             cout;
    logic [VEC_W-1:0] prod;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [VEC_W-1:0] in_sum = '0;
  logic [VEC_W-1:0] in_carry = '0;
  rs_tag_t          in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [VEC_W-1:0] out_product;
  rs_tag_t          out_tag;
  logic             out_cout;
  logic             chk_en = 1'b1;
  logic             chk_violation;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_fire = 0;
  logic        last_acc = 1'b0;
  logic        stall_prev = 1'b0;
  logic [68:0] held = '0;

  wallace_final_cpa u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_carry(in_carry), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_tag(out_tag), .out_cout(out_cout)
  );

  cpa_checker u_chk (
    .clk(clk), .rst_n(rst_n), .en(chk_en),
    .out_valid(out_valid), .out_cout(out_cout), .violation(chk_violation)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Legal pair: sum + carry never overflows, carry has bit 0 clear.
  task automatic gen_legal(output logic [63:0] s, output logic [63:0] c);
    logic [63:0] t;
    logic [63:0] r;
    logic [64:0] t1;
    t  = {$urandom, $urandom};
    r  = {$urandom, $urandom};
    t1 = {1'b0, t} + 65'd1;
    s  = 64'({1'b0, r} % t1);
    c  = (t - s) & ~64'd1;
    s  = t - c;
  endtask

  // One clock of handshake bookkeeping; entered and left at posedge+1.
  task automatic step();
    exp_t e;
    logic acc;
    logic fire;
    #1;
    acc  = in_valid && in_ready;
    fire = out_valid && out_ready;
    if (stall_prev) check_eq("stall_hold", 80'({out_tag, out_cout, out_product}), 80'(held));
    if (fire && !flush) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected_out", 80'(sb.size()), 80'd1);
      end else begin
        e = sb.pop_front();
        check_eq("product", 80'(out_product), 80'(e.prod));
        check_eq("tag", 80'(out_tag), 80'(e.tag));
        check_eq("cout", 80'(out_cout), 80'(e.cout));
      end
      n_fire++;
    end
    if (flush) sb.delete();
    if (acc) begin
      e.tag = in_tag;
      {e.cout, e.prod} = {1'b0, in_sum} + {1'b0, in_carry};
      sb.push_back(e);
    end
    stall_prev = out_valid && !out_ready && !flush;
    held       = {out_tag, out_cout, out_product};
    last_acc   = acc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int f0;
    int sent;
    int acc_cnt;
    int cyc;
    logic need_new;

    #12;
    check_eq("rst_out_valid", 80'(out_valid), 80'd0);
    check_eq("rst_product", 80'(out_product), 80'd0);
    check_eq("rst_tag", 80'(out_tag), 80'd0);
    check_eq("rst_cout", 80'(out_cout), 80'd0);
    check_eq("rst_in_ready", 80'(in_ready), 80'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single op, 2-cycle latency
    in_valid = 1'b1; in_sum = 64'h0000_0000_FFFF_FFFF; in_carry = 64'h1; in_tag = 4'd3;
    step();
    in_valid = 1'b0;
    check_eq("t1_not_yet", 80'(out_valid), 80'd0);
    step();
    check_eq("t1_valid", 80'(out_valid), 80'd1);
    check_eq("t1_product", 80'(out_product), 80'h0000_0001_0000_0000);
    check_eq("t1_tag", 80'(out_tag), 80'd3);
    check_eq("t1_cout", 80'(out_cout), 80'd0);
    step();
    check_eq("t1_sb_empty", 80'(sb.size()), 80'd0);

    // back-to-back stream
    f0 = n_fire;
    for (int i = 0; i < 8; i++) begin
      gen_legal(in_sum, in_carry);
      in_tag = rs_tag_t'(i); in_valid = 1'b1;
      #1 check_eq("t2_in_ready", 80'(in_ready), 80'd1);
      step();
      if (i >= 1) check_eq("t2_out_valid", 80'(out_valid), 80'd1);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check_eq("t2_fire_count", 80'(n_fire - f0), 80'd8);

    // backpressure for three cycles mid-stream
    f0 = n_fire; sent = 0; need_new = 1'b1;
    for (int c = 0; c < 25; c++) begin
      out_ready = !(c >= 5 && c < 8);
      if (sent < 12) begin
        if (need_new) begin
          gen_legal(in_sum, in_carry);
          in_tag = rs_tag_t'(sent);
        end
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 5 && c < 8) check_eq("t3_in_ready_full", 80'(in_ready), 80'd0);
      step();
      if (last_acc) sent++;
      need_new = last_acc;
    end
    check_eq("t3_sent", 80'(sent), 80'd12);
    check_eq("t3_fire_count", 80'(n_fire - f0), 80'd12);
    check_eq("t3_sb_empty", 80'(sb.size()), 80'd0);

    // flush with both stages full and an op waiting
    out_ready = 1'b1;
    gen_legal(in_sum, in_carry); in_tag = 4'd5; in_valid = 1'b1;
    step();
    gen_legal(in_sum, in_carry); in_tag = 4'd6;
    step();
    gen_legal(in_sum, in_carry); in_tag = 4'd7; flush = 1'b1;
    #1 check_eq("t4_in_ready_flush", 80'(in_ready), 80'd0);
    f0 = n_fire;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check_eq("t4_out_valid", 80'(out_valid), 80'd0);
    check_eq("t4_s1_empty", 80'(u_dut.s1_v_r), 80'd0);
    gen_legal(in_sum, in_carry); in_tag = 4'd8; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("t4_lat_not_yet", 80'(out_valid), 80'd0);
    step();
    check_eq("t4_lat_valid", 80'(out_valid), 80'd1);
    check_eq("t4_lat_tag", 80'(out_tag), 80'd8);
    step();
    check_eq("t4_fire_count", 80'(n_fire - f0), 80'd1);

    // wrap and full carry chain: illegal products the checker must flag
    chk_en = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_sum   = (k == 0) ? {64{1'b1}} : 64'h8000_0000_0000_0000;
      in_carry = (k == 0) ? 64'h1 : 64'h8000_0000_0000_0000;
      in_tag = rs_tag_t'(9 + k); in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      check_eq("t5_valid", 80'(out_valid), 80'd1);
      check_eq("t5_product", 80'(out_product), 80'd0);
      check_eq("t5_cout", 80'(out_cout), 80'd1);
      check_eq("t5_flagged", 80'(chk_violation), 80'd1);
      step();
    end
    chk_en = 1'b1;

    // async reset with both stages full
    gen_legal(in_sum, in_carry); in_tag = 4'd11; in_valid = 1'b1;
    step();
    gen_legal(in_sum, in_carry); in_tag = 4'd12;
    step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_out_valid", 80'(out_valid), 80'd0);
    check_eq("t6_product", 80'(out_product), 80'd0);
    check_eq("t6_s1_empty", 80'(u_dut.s1_v_r), 80'd0);
    sb.delete(); stall_prev = 1'b0; in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    gen_legal(in_sum, in_carry); in_tag = 4'd14; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check_eq("t6_valid", 80'(out_valid), 80'd1);
    check_eq("t6_tag", 80'(out_tag), 80'd14);
    step();
    check_eq("t6_sb_empty", 80'(sb.size()), 80'd0);

    // random stall/flush soak
    acc_cnt = 0; cyc = 0; need_new = 1'b1;
    while (acc_cnt < 10000 && cyc < 60000) begin
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
      if (need_new) begin
        if ($urandom_range(0, 4) != 0) begin
          gen_legal(in_sum, in_carry);
          in_tag = rs_tag_t'($urandom_range(0, 15));
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      step();
      if (last_acc) acc_cnt++;
      need_new = last_acc || !in_valid;
      cyc++;
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check_eq("soak_ops", 80'(acc_cnt), 80'd10000);
    check_eq("soak_sb_empty", 80'(sb.size()), 80'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
